// File: rtl/uart_term_rx.sv
// ============================================================================
// Module   : uart_term_rx
// Purpose  : Terminal-side 8N1 UART receiver with mid-bit sampling and a
//            show-ahead valid/ready FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_term_rx #(
   parameter int BAUD_DIV   = 234,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       busy_o
);

   localparam int c_CNT_W = $clog2(BAUD_DIV);
   localparam int c_AW    = $clog2(FIFO_DEPTH);

   localparam logic [c_CNT_W-1:0] c_HALF_LOAD = c_CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_FULL_LOAD = c_CNT_W'(BAUD_DIV - 1);

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_START = 3'd1;
   localparam logic [2:0] c_ST_DATA  = 3'd2;
   localparam logic [2:0] c_ST_STOP  = 3'd3;
   localparam logic [2:0] c_ST_BREAK = 3'd4;

   logic               r_sync1;
   logic               r_sync2;
   logic               r_rx_prev;
   logic [1:0]         r_warm;
   logic [2:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_frame_err;
   logic               r_overrun;
   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [c_AW:0]      r_wr_ptr;
   logic [c_AW:0]      r_rd_ptr;

   logic w_expire;
   logic w_stop_ok;
   logic w_stop_bad;
   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   assign w_expire   = (r_cnt == '0);
   assign w_stop_ok  = (r_state == c_ST_STOP) && w_expire && r_sync2;
   assign w_stop_bad = (r_state == c_ST_STOP) && w_expire && !r_sync2;
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_pop      = !w_empty && rx_ready_i;
   assign w_push     = w_stop_ok && (!w_full || w_pop);
   assign w_drop     = w_stop_ok && w_full && !w_pop;

   // The sync flops reset high, so r_rx_prev only reports "high" once rx_s
   // carries real line data; a line held low out of reset is not an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_warm    <= 2'b00;
         r_rx_prev <= 1'b0;
      end else begin
         r_sync1   <= rx_i;
         r_sync2   <= r_sync1;
         r_warm    <= {r_warm[0], 1'b1};
         r_rx_prev <= r_sync2 & r_warm[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_ST_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (!r_sync2 && r_rx_prev) begin
                  r_cnt   <= c_HALF_LOAD;
                  r_state <= c_ST_START;
               end
            end
            c_ST_START: begin
               if (!w_expire) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_sync2) begin
                  r_state <= c_ST_IDLE;
               end else begin
                  r_cnt     <= c_FULL_LOAD;
                  r_bit_idx <= '0;
                  r_state   <= c_ST_DATA;
               end
            end
            c_ST_DATA: begin
               if (!w_expire) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_shift[r_bit_idx] <= r_sync2;
                  r_cnt              <= c_FULL_LOAD;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= c_ST_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            c_ST_STOP: begin
               if (!w_expire) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_state <= r_sync2 ? c_ST_IDLE : c_ST_BREAK;
               end
            end
            c_ST_BREAK: begin
               if (r_sync2) begin
                  r_state <= c_ST_IDLE;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         r_frame_err <= w_stop_bad;
         r_overrun   <= w_drop;
         if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
            r_wr_ptr                  <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

   assign rx_data_o   = r_mem[r_rd_ptr[c_AW-1:0]];
   assign rx_valid_o  = !w_empty;
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;
   assign busy_o      = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_term_rx.sv
// ============================================================================
// Module   : tb_uart_term_rx
// Purpose  : Scoreboard bench for uart_term_rx driving directed 8N1 frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_term_rx;

   localparam int BD = 234;

   logic       clk;
   logic       rst_n;
   logic       rx_i;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       rx_ready_i;
   logic       frame_err_o;
   logic       overrun_o;
   logic       busy_o;

   int         n_checks;
   int         n_errors;
   int         fe_seen;
   int         ov_seen;
   logic [7:0] exp_q[$];

   uart_term_rx #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_i       (rx_i),
      .rx_data_o  (rx_data_o),
      .rx_valid_o (rx_valid_o),
      .rx_ready_i (rx_ready_i),
      .frame_err_o(frame_err_o),
      .overrun_o  (overrun_o),
      .busy_o     (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: pops the scoreboard on every accepted byte and tallies pulses.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rx_valid_o && rx_ready_i) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL unexpected_byte: got 0x%02h, none expected", rx_data_o);
               end else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  if (rx_data_o !== e) begin
                     n_errors++;
                     $display("FAIL rx_byte: got 0x%02h, expected 0x%02h", rx_data_o, e);
                  end
               end
            end
            if (frame_err_o) fe_seen++;
            if (overrun_o) ov_seen++;
            if (frame_err_o || overrun_o) begin
               n_checks++;
               if (frame_err_o && overrun_o) begin
                  n_errors++;
                  $display("FAIL pulse_overlap: frame_err=1 overrun=1, expected at most one");
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_val);
      rx_i = 1'b0;
      wait_cycles(BD);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         wait_cycles(BD);
      end
      rx_i = stop_val;
      wait_cycles(BD);
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 3 * BD) begin
         wait_cycles(1);
         k++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] seq5 [5];
      logic [7:0] b7e;
      n_checks   = 0;
      n_errors   = 0;
      fe_seen    = 0;
      ov_seen    = 0;
      rx_i       = 1'b1;
      rx_ready_i = 1'b0;
      rst_n      = 1'b0;
      wait_cycles(5);
      chk("reset_valid", rx_valid_o, 0);
      chk("reset_busy", busy_o, 0);
      chk("reset_data", rx_data_o, 0);
      chk("reset_ferr", frame_err_o, 0);
      chk("reset_ovr", overrun_o, 0);
      rst_n = 1'b1;
      wait_cycles(20);

      // Single byte, busy timing around the stop bit
      rx_ready_i = 1'b1;
      exp_q.push_back(8'h41);
      fork
         send_byte(8'h41, 1'b1);
         begin
            wait_cycles(9 * BD + 100);
            chk("busy_before_stop_sample", busy_o, 1);
         end
      join
      chk("busy_after_frame", busy_o, 0);
      wait_drain("drain_41");
      wait_cycles(BD);
      chk("no_ferr_41", fe_seen, 0);
      chk("no_ovr_41", ov_seen, 0);

      // False start glitch
      rx_i = 1'b0;
      wait_cycles(50);
      rx_i = 1'b1;
      wait_cycles(300);
      chk("glitch_busy", busy_o, 0);
      chk("glitch_valid", rx_valid_o, 0);
      chk("glitch_ferr", fe_seen, 0);
      exp_q.push_back(8'h5A);
      send_byte(8'h5A, 1'b1);
      wait_drain("drain_5a");

      // Framing error with a long break
      send_byte(8'h33, 1'b0);
      wait_cycles(1000);
      chk("break_busy", busy_o, 1);
      chk("ferr_count", fe_seen, 1);
      chk("ferr_no_byte", rx_valid_o, 0);
      rx_i = 1'b1;
      wait_cycles(10);
      chk("break_exit_busy", busy_o, 0);
      exp_q.push_back(8'h55);
      send_byte(8'h55, 1'b1);
      wait_drain("drain_55");

      // Overrun: five bytes into a four-entry FIFO with no consumer
      rx_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h10 + i));
      for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b1);
      wait_cycles(20);
      chk("ovr_count", ov_seen, 1);
      chk("full_valid", rx_valid_o, 1);
      chk("full_head", rx_data_o, 8'h10);
      rx_ready_i = 1'b1;
      wait_drain("drain_fifo");
      wait_cycles(2);
      chk("fifo_empty_after", rx_valid_o, 0);

      // Back-to-back frames
      seq5[0] = 8'h41; seq5[1] = 8'h42; seq5[2] = 8'h43; seq5[3] = 8'h0D; seq5[4] = 8'h0A;
      for (int i = 0; i < 5; i++) exp_q.push_back(seq5[i]);
      for (int i = 0; i < 5; i++) send_byte(seq5[i], 1'b1);
      wait_drain("drain_b2b");
      wait_cycles(20);
      chk("b2b_ferr", fe_seen, 1);
      chk("b2b_ovr", ov_seen, 1);

      // Reset in the middle of a frame while the FIFO holds a byte
      rx_ready_i = 1'b0;
      send_byte(8'h22, 1'b1);
      wait_cycles(10);
      chk("held_valid", rx_valid_o, 1);
      chk("held_data", rx_data_o, 8'h22);
      b7e  = 8'h7E;
      rx_i = 1'b0;
      wait_cycles(BD);
      for (int i = 0; i < 4; i++) begin
         rx_i = b7e[i];
         wait_cycles(i == 3 ? BD / 2 : BD);
      end
      chk("midframe_busy", busy_o, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_valid", rx_valid_o, 0);
      chk("rst_busy", busy_o, 0);
      rx_i = 1'b1;
      wait_cycles(5);
      rst_n      = 1'b1;
      rx_ready_i = 1'b1;
      wait_cycles(3 * BD);
      chk("post_rst_valid", rx_valid_o, 0);
      chk("post_rst_busy", busy_o, 0);
      exp_q.push_back(8'h7E);
      send_byte(8'h7E, 1'b1);
      wait_drain("drain_7e");
      wait_cycles(20);
      chk("final_ferr", fe_seen, 1);
      chk("final_ovr", ov_seen, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_term_rx.md
Name: uart_term_rx

Overview:
- Terminal-side UART receiver: decodes the SoC's UART TX line (8N1, LSB first) into a byte stream for simulation monitors and FPGA debug capture.
- Complements the bench-side transmitter that drives the SoC's UART RX on GPIO bit 16.
- Sits outside the SoC on the gpio_out UART TX bit.
- Consists of an input synchronizer, a mid-bit sampling FSM and a small show-ahead FIFO with valid/ready output.

Parameters:
BAUD_DIV, 234, clock cycles per UART bit (27 MHz / 115200); must be >= 8
FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_i  input  1  serial line from SoC UART TX; asynchronous; idles high
rx_data_o  output  8  FIFO head byte; valid only when rx_valid_o=1
rx_valid_o  output  1  FIFO not empty
rx_ready_i  input  1  consumer accepts head byte when rx_valid_o & rx_ready_i
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: completed byte dropped, FIFO full
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset (async assert, sync deassert by the flops): sync flops=1, FSM=IDLE, bit counter=0, baud counter=0, FIFO empty, rx_data_o=0, all output pulses=0, busy_o=0.
- Synchronizer: two flops on rx_i. rx_s is the second flop. All decisions use rx_s, which adds 2 cycles of latency.
- IDLE:
  - A cycle with rx_s=0 (previous rx_s=1) loads baud counter with BAUD_DIV/2-1 (integer division) and enters START.
  - A line held low out of reset is not a start: a 1->0 edge is required.
- START:
  - Counts down to 0, then samples rx_s.
  - rx_s=1: false start, back to IDLE, no outputs.
  - rx_s=0: load BAUD_DIV-1, bit index=0, enter DATA.
- DATA:
  - At each counter expiry, shift rx_s into bit[index], LSB first, then reload BAUD_DIV-1.
  - After index 7 is sampled, enter STOP.
- STOP: at expiry, sample rx_s.
  - rx_s=1: push byte to FIFO and go to IDLE in the same cycle. This is the mid-stop return, so back-to-back frames are supported.
  - rx_s=0: pulse frame_err_o, drop the byte, enter BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. No start detection while the line stays low.
- FIFO:
  - Push and pop use separate read and write pointers of log2(FIFO_DEPTH)+1 bits.
  - rx_valid_o = !empty. rx_data_o = mem[rd_ptr] (show-ahead).
  - Pop on rx_valid_o & rx_ready_i.
  - Push when full and no pop in the same cycle: byte dropped, overrun_o pulses, FIFO contents unchanged.
  - Push when full with a pop in the same cycle: both happen, no overrun.
  - Push and pop on a non-full, non-empty FIFO: occupancy unchanged.
- Latency: rx_valid_o rises, and the byte appears on rx_data_o, on the cycle after the stop-sample cycle when the FIFO was empty.
- Counters wrap never: the baud counter is reloaded before it underflows.
- frame_err_o and overrun_o are registered and high for exactly one cycle. They are never high in the same cycle.
- rx_ready_i while rx_valid_o=0: no effect.
- Reset mid-frame: everything returns to reset values and FIFO contents are discarded. After reset, the first byte received must start with a fresh 1->0 edge.

Test Plan:
- Idle line, then 0x41 sent at 234 cycles/bit, rx_ready_i=1 -> exactly one transfer of rx_data_o=0x41. frame_err_o and overrun_o never pulse. busy_o returns to 0 about 117 cycles after the stop-bit start.
- rx_i low glitch of 50 cycles, then high -> FSM returns to IDLE from START. No rx_valid_o, no pulses. A following 0x5A is received correctly.
- Frame 0x33 with stop bit forced 0 and the line held low 1000 cycles before returning high -> one frame_err_o pulse, no byte. The next frame 0x55 is received as 0x55.
- rx_ready_i=0, five back-to-back bytes 0x10..0x14 -> FIFO fills with 0x10..0x13 and overrun_o pulses once on the fifth byte. Then rx_ready_i=1 -> pops 0x10,0x11,0x12,0x13 in order, then rx_valid_o=0.
- rx_ready_i=1, back-to-back "A","B","C",0x0D,0x0A with no idle between stop and start -> all five received in order, no errors.
- rst_n asserted during bit 3 of 0x7E, while the FIFO holds 0x22 -> rx_valid_o=0 and busy_o=0 immediately. After release, 0x7E is sent again and received as 0x7E only.
